// File: rtl/muldiv_pkg.sv
// muldiv_pkg: opcode and FSM state encodings plus shared constants for the multiply/divide unit
package muldiv_pkg;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [63:0] DIV_BY_ZERO_LO = '1;
endpackage

// File: rtl/muldiv_shift_core.sv
// muldiv_shift_core: one shift-add (multiply) or restoring shift-subtract (divide) step on {acc_hi,acc_lo}
module muldiv_shift_core #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shl;
    logic [WIDTH:0] diff;
    logic           ge;
    assign sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign shl  = {acc_hi, acc_lo[WIDTH-1]};
    assign ge   = shl >= {1'b0, opnd};
    assign diff = shl - {1'b0, opnd};
    assign nxt_hi = is_div ? (ge ? diff[WIDTH-1:0] : shl[WIDTH-1:0]) : sum[WIDTH:1];
    assign nxt_lo = is_div ? {acc_lo[WIDTH-2:0], ge} : {sum[0], acc_lo[WIDTH-1:1]};
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO; MULDIV_FAST_MULT_EN selects a single-multiply product path
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] BusA,
    input  logic [WIDTH-1:0] BusB,
    input  logic             HiWrEn,
    input  logic             LoWrEn,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);
`ifdef MULDIV_FAST_MULT_EN
    localparam logic FAST_MULT = 1'b1;
`else
    localparam logic FAST_MULT = 1'b0;
`endif
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic               is_div_q;
    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   nxt_hi;
    logic [WIDTH-1:0]   nxt_lo;
    logic               is_div;
    logic               signed_op;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign is_div    = Op == OP_DIV || Op == OP_DIVU;
    assign signed_op = Op == OP_MULT || Op == OP_DIV;
    assign mag_a     = (signed_op && BusA[WIDTH-1]) ? -BusA : BusA;
    assign mag_b     = (signed_op && BusB[WIDTH-1]) ? -BusB : BusB;

    // Signed results are rebuilt from magnitudes; divide by zero reports all-ones quotient and the raw dividend
    assign prod   = (neg_a ^ neg_b) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign quo    = (neg_a ^ neg_b) ? -acc_lo : acc_lo;
    assign rem    = neg_a ? -acc_hi : acc_hi;
    assign fix_hi = !is_div_q ? prod[2*WIDTH-1:WIDTH] : (opnd == '0) ? a_raw : rem;
    assign fix_lo = !is_div_q ? prod[WIDTH-1:0] : (opnd == '0) ? DIV_BY_ZERO_LO[WIDTH-1:0] : quo;

    assign Busy = state != S_IDLE;
    assign Done = state == S_DONE;

    muldiv_shift_core #(.WIDTH(WIDTH)) u_core (
        .is_div (is_div_q),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo),
        .opnd   (opnd),
        .nxt_hi (nxt_hi),
        .nxt_lo (nxt_lo)
    );

    // Sequencer: capture operands on Start, iterate WIDTH steps, then sign fix and done
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            is_div_q <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            a_raw    <= '0;
            opnd     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        is_div_q <= is_div;
                        neg_a    <= signed_op & BusA[WIDTH-1];
                        neg_b    <= signed_op & BusB[WIDTH-1];
                        a_raw    <= BusA;
                        cnt      <= '0;
                        opnd     <= is_div ? mag_b : mag_a;
                        if (FAST_MULT && !is_div) begin
                            state            <= S_FIX;
                            {acc_hi, acc_lo} <= {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
                        end else begin
                            state  <= S_RUN;
                            acc_hi <= '0;
                            acc_lo <= is_div ? mag_a : mag_b;
                        end
                    end
                end
                S_RUN: begin
                    acc_hi <= nxt_hi;
                    acc_lo <= nxt_lo;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST)
                        state <= S_FIX;
                end
                S_FIX:   state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // HI/LO: result lands on the edge into DONE; MTHI/MTLO only when idle and not starting
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Hi <= '0;
            Lo <= '0;
        end else if (state == S_FIX) begin
            Hi <= fix_hi;
            Lo <= fix_lo;
        end else if (state == S_IDLE && !Start) begin
            if (HiWrEn)
                Hi <= BusA;
            if (LoWrEn)
                Lo <= BusA;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (honours MULDIV_FAST_MULT_EN)
module tb_muldiv_unit;
    import muldiv_pkg::*;
`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [31:0] BusA = '0;
    logic [31:0] BusB = '0;
    logic        HiWrEn = 1'b0;
    logic        LoWrEn = 1'b0;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;
    int          errors = 0;
    int          checks = 0;
    int          cyc;
    int          done_seen;

    muldiv_unit #(.WIDTH(32)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Start  (Start),
        .Op     (Op),
        .BusA   (BusA),
        .BusB   (BusB),
        .HiWrEn (HiWrEn),
        .LoWrEn (LoWrEn),
        .Busy   (Busy),
        .Done   (Done),
        .Hi     (Hi),
        .Lo     (Lo)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_done();
        while (!Done && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        Op = op;
        BusA = a;
        BusB = b;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        Op = ~op;
        BusA = 32'hDEAD_BEEF;
        BusB = 32'h5A5A_5A5A;
        cyc = 1;
        wait_done();
    endtask

    initial begin
        tick();
        tick();
        Reset = 1'b0;
        chk("reset busy", Busy, 1'b0);
        chk("reset done", Done, 1'b0);
        chk("reset hi", Hi, 32'h0);
        chk("reset lo", Lo, 32'h0);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu latency", cyc, MUL_LAT);
        chk("multu busy at done", Busy, 1'b1);
        chk("multu hi", Hi, 32'hFFFF_FFFE);
        chk("multu lo", Lo, 32'h0000_0001);
        tick();
        chk("idle after done busy", Busy, 1'b0);
        chk("idle after done pulse", Done, 1'b0);

        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        chk("mult neg hi", Hi, 32'hFFFF_FFFF);
        chk("mult neg lo", Lo, 32'hFFFF_FFEB);
        tick();

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        chk("div latency", cyc, DIV_LAT);
        chk("div -7/2 lo", Lo, 32'hFFFF_FFFD);
        chk("div -7/2 hi", Hi, 32'hFFFF_FFFF);
        tick();

        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        chk("div 7/-2 lo", Lo, 32'hFFFF_FFFD);
        chk("div 7/-2 hi", Hi, 32'h0000_0001);
        tick();

        issue(OP_DIVU, 32'd100, 32'd0);
        chk("divu by zero lo", Lo, 32'hFFFF_FFFF);
        chk("divu by zero hi", Hi, 32'd100);
        tick();

        issue(OP_DIV, 32'hFFFF_FFF0, 32'd0);
        chk("div by zero lo", Lo, 32'hFFFF_FFFF);
        chk("div by zero hi", Hi, 32'hFFFF_FFF0);
        tick();

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div overflow lo", Lo, 32'h8000_0000);
        chk("div overflow hi", Hi, 32'h0);
        tick();

        Op = OP_DIVU;
        BusA = 32'd10;
        BusB = 32'd3;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        cyc = 1;
        while (!Done && cyc < 200) begin
            Start = (cyc == 5);
            Op = OP_MULTU;
            BusA = 32'd50;
            BusB = 32'd7;
            tick();
            cyc++;
        end
        Start = 1'b0;
        chk("start while busy latency", cyc, DIV_LAT);
        chk("start while busy lo", Lo, 32'd3);
        chk("start while busy hi", Hi, 32'd1);
        tick();
        chk("no queued op", Busy, 1'b0);

        HiWrEn = 1'b1;
        BusA = 32'd5;
        tick();
        HiWrEn = 1'b0;
        LoWrEn = 1'b1;
        BusA = 32'd9;
        tick();
        LoWrEn = 1'b0;
        chk("mthi 5", Hi, 32'd5);
        chk("mtlo 9", Lo, 32'd9);
        Op = (MUL_LAT == 2) ? OP_DIVU : OP_MULTU;
        BusA = 32'd6;
        BusB = 32'd7;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 1; i < 10; i++)
            tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("abort busy", Busy, 1'b0);
        chk("abort hi", Hi, 32'h0);
        chk("abort lo", Lo, 32'h0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done)
                done_seen++;
            tick();
        end
        chk("abort no done", done_seen, 0);

        HiWrEn = 1'b1;
        BusA = 32'h0000_1234;
        tick();
        HiWrEn = 1'b0;
        chk("mthi idle", Hi, 32'h0000_1234);
        HiWrEn = 1'b1;
        LoWrEn = 1'b1;
        BusA = 32'h0000_9999;
        BusB = 32'd2;
        Op = OP_MULTU;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("start wins hi", Hi, 32'h0000_1234);
        chk("start wins lo", Lo, 32'h0);
        BusA = 32'h0000_7777;
        tick();
        chk("mt while busy hi", Hi, (MUL_LAT == 2) ? 32'h0 : 32'h0000_1234);
        chk("mt while busy lo", Lo, (MUL_LAT == 2) ? 32'h0001_3332 : 32'h0);
        HiWrEn = 1'b0;
        LoWrEn = 1'b0;
        cyc = 2;
        wait_done();
        chk("captured product lo", Lo, 32'h0001_3332);
        chk("captured product hi", Hi, 32'h0);
        tick();
        tick();

        HiWrEn = 1'b1;
        LoWrEn = 1'b1;
        BusA = 32'h0000_ABCD;
        tick();
        HiWrEn = 1'b0;
        LoWrEn = 1'b0;
        chk("both write hi", Hi, 32'h0000_ABCD);
        chk("both write lo", Lo, 32'h0000_ABCD);

        issue(OP_MULTU, 32'd6, 32'd7);
        chk("multu 6*7 latency", cyc, MUL_LAT);
        chk("multu 6*7 lo", Lo, 32'd42);
        chk("multu 6*7 hi", Hi, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
